// File: rtl/bnn_layer_loader.sv
// Loads a daisy-chained BNN parameter chain from a byte stream, reads back the old
// chain contents, then runs a two-stage registered inference pipeline.
module bnn_layer_loader #(
   parameter int unsigned NEURONS   = 8,
   parameter int unsigned INPUTS    = 8,
   parameter int unsigned BIAS_BITS = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_start,
   input  logic [7:0]         param_data,
   input  logic               param_valid,
   output logic               param_ready,
   output logic               setup,
   output logic               param_in,
   input  logic               param_out,
   output logic [7:0]         readback_data,
   output logic               readback_valid,
   output logic               load_done,
   input  logic [INPUTS-1:0]  in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [INPUTS-1:0]  layer_in,
   input  logic [NEURONS-1:0] axons,
   output logic [NEURONS-1:0] out_data,
   output logic               out_valid
);

   localparam int unsigned CHAIN_BITS = NEURONS * (INPUTS + BIAS_BITS);
   localparam int unsigned NBYTES     = (CHAIN_BITS + 7) / 8;
   localparam int unsigned CNT_W      = $clog2(CHAIN_BITS + 1);
   localparam int unsigned BYTE_W     = $clog2(NBYTES + 1);

   typedef enum logic [1:0] {StIdle, StLoad, StRun} state_t;

   state_t               state_q, state_d;
   logic [7:0]           buf_q, buf_d;
   logic                 buf_valid_q, buf_valid_d;
   logic [2:0]           bit_idx_q, bit_idx_d;
   logic [CNT_W-1:0]     bits_left_q, bits_left_d;
   logic [BYTE_W-1:0]    bytes_q, bytes_d;
   logic [7:0]           rb_shift_q, rb_shift_d;
   logic [2:0]           rb_cnt_q, rb_cnt_d;
   logic [7:0]           rb_data_q, rb_data_d;
   logic                 rb_valid_q, rb_valid_d;
   logic                 done_q, done_d;
   logic [INPUTS-1:0]    layer_q, layer_d;
   logic                 stage_q, stage_d;
   logic [NEURONS-1:0]   out_q, out_d;
   logic                 out_valid_q, out_valid_d;

   logic                 last_bit;
   logic                 start_load;
   logic                 accept;
   logic                 abort;
   logic [7:0]           rb_next;

   always_comb begin
      state_d     = state_q;
      buf_d       = buf_q;
      buf_valid_d = buf_valid_q;
      bit_idx_d   = bit_idx_q;
      bits_left_d = bits_left_q;
      bytes_d     = bytes_q;
      rb_shift_d  = rb_shift_q;
      rb_cnt_d    = rb_cnt_q;
      rb_data_d   = rb_data_q;
      rb_valid_d  = 1'b0;
      start_load  = 1'b0;
      rb_next     = {rb_shift_q[6:0], param_out};

      setup       = (state_q == StLoad) && buf_valid_q && (bits_left_q != '0);
      param_in    = setup & buf_q[7];
      last_bit    = setup && (bits_left_q == CNT_W'(1));
      param_ready = (state_q == StLoad) && (bytes_q < BYTE_W'(NBYTES)) &&
                    (!buf_valid_q || (setup && bit_idx_q == 3'd7));
      in_ready    = (state_q == StRun);
      accept      = in_valid && in_ready;
      abort       = (state_q == StRun) && load_start;
      done_d      = last_bit;

      unique case (state_q)
         StIdle:  if (load_start) start_load = 1'b1;
         StLoad:  if (last_bit) state_d = StRun;
         StRun:   if (load_start) start_load = 1'b1;
         default: state_d = StIdle;
      endcase

      if (setup) begin
         buf_d       = {buf_q[6:0], 1'b0};
         bit_idx_d   = bit_idx_q + 3'd1;
         bits_left_d = bits_left_q - CNT_W'(1);
         // Final sample of a load flushes a partial byte left-aligned.
         if (rb_cnt_q == 3'd7 || last_bit) begin
            rb_data_d  = rb_next << (3'd7 - rb_cnt_q);
            rb_valid_d = 1'b1;
            rb_cnt_d   = 3'd0;
            rb_shift_d = 8'h00;
         end else begin
            rb_cnt_d   = rb_cnt_q + 3'd1;
            rb_shift_d = rb_next;
         end
         if (bit_idx_q == 3'd7 || last_bit) buf_valid_d = 1'b0;
         if (last_bit) buf_d = 8'h00;
      end

      if (param_valid && param_ready) begin
         buf_d       = param_data;
         buf_valid_d = 1'b1;
         bit_idx_d   = 3'd0;
         bytes_d     = bytes_q + BYTE_W'(1);
      end

      if (start_load) begin
         state_d     = StLoad;
         buf_d       = 8'h00;
         buf_valid_d = 1'b0;
         bit_idx_d   = 3'd0;
         bits_left_d = CNT_W'(CHAIN_BITS);
         bytes_d     = '0;
         rb_shift_d  = 8'h00;
         rb_cnt_d    = 3'd0;
      end

      layer_d     = accept ? in_data : layer_q;
      stage_d     = accept && !abort;
      out_d       = stage_q ? axons : out_q;
      out_valid_d = stage_q && !abort;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         buf_q       <= 8'h00;
         buf_valid_q <= 1'b0;
         bit_idx_q   <= 3'd0;
         bits_left_q <= '0;
         bytes_q     <= '0;
         rb_shift_q  <= 8'h00;
         rb_cnt_q    <= 3'd0;
         rb_data_q   <= 8'h00;
         rb_valid_q  <= 1'b0;
         done_q      <= 1'b0;
         layer_q     <= '0;
         stage_q     <= 1'b0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         buf_valid_q <= buf_valid_d;
         bit_idx_q   <= bit_idx_d;
         bits_left_q <= bits_left_d;
         bytes_q     <= bytes_d;
         rb_shift_q  <= rb_shift_d;
         rb_cnt_q    <= rb_cnt_d;
         rb_data_q   <= rb_data_d;
         rb_valid_q  <= rb_valid_d;
         done_q      <= done_d;
         layer_q     <= layer_d;
         stage_q     <= stage_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign readback_data  = rb_data_q;
   assign readback_valid = rb_valid_q;
   assign load_done      = done_q;
   assign layer_in       = layer_q;
   assign out_data       = out_q;
   assign out_valid      = out_valid_q;

endmodule
